// File: rtl/sprite_renderer_if.sv
// Bundle of the sprite renderer's start, ROM and LCD pixel-write signals.
// The renderer uses the slave view; the upstream/ROM/LCD side uses the master view.
interface sprite_renderer_if;
    logic        startFrame;
    logic [7:0]  xSprite;
    logic [8:0]  ySprite;
    logic [3:0]  spriteId;
    logic [13:0] romAddr;
    logic [15:0] romData;
    logic        pixelWrite;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelReady;
    logic        busy;
    logic        frameDone;

    modport slave (
        input  startFrame, xSprite, ySprite, spriteId, romData, pixelReady,
        output romAddr, pixelWrite, pixelX, pixelY, pixelData, busy, frameDone
    );

    modport master (
        output startFrame, xSprite, ySprite, spriteId, romData, pixelReady,
        input  romAddr, pixelWrite, pixelX, pixelY, pixelData, busy, frameDone
    );
endinterface

// File: rtl/sprite_renderer.sv
// Erases the previous sprite box with the background colour, then draws the new
// sprite from ROM onto the LT24 LCD through a ready/valid pixel-write port.
module sprite_renderer #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter logic [15:0] BG_COLOUR   = 16'hFFFF,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter int          LCD_W       = 240,
    parameter int          LCD_H       = 320
) (
    input  logic               clock,
    input  logic               resetn,
    sprite_renderer_if.slave   bus
);

    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SPRITE_H - 1);
    localparam logic [13:0]   ROM_AREA   = 14'(SPRITE_W * SPRITE_H);
    localparam logic [13:0]   ROM_STRIDE = 14'(SPRITE_W);
    localparam logic [9:0]    X_LIMIT    = 10'(LCD_W);
    localparam logic [9:0]    Y_LIMIT    = 10'(LCD_H);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ERASE    = 3'd1,
        S_FETCH    = 3'd2,
        S_WAIT_ROM = 3'd3,
        S_DRAW     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Coordinates are widened to 10 bits so the range test never sees a wrapped value.
    function automatic logic is_clipped(input logic [9:0] px, input logic [9:0] py);
        is_clipped = (px >= X_LIMIT) || (py >= Y_LIMIT);
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   w_row_nx;
    logic [CW-1:0]   w_col_nx;
    logic [RW-1:0]   w_row_adv;
    logic [CW-1:0]   w_col_adv;
    logic            w_last;

    logic [7:0]      r_cur_x;
    logic [8:0]      r_cur_y;
    logic [3:0]      r_cur_id;
    logic [7:0]      r_prev_x;
    logic [8:0]      r_prev_y;
    logic            r_prev_valid;

    logic            r_pixel_write;
    logic [7:0]      r_pixel_x;
    logic [8:0]      r_pixel_y;
    logic [15:0]     r_pixel_data;
    logic [13:0]     r_rom_addr;
    logic            r_busy;
    logic            r_frame_done;

    logic [9:0]      w_erase_x;
    logic [9:0]      w_erase_y;
    logic            w_erase_clip;
    logic [9:0]      w_draw_x;
    logic [9:0]      w_draw_y;
    logic            w_draw_skip;
    logic [3:0]      w_id;
    logic [13:0]     w_rom_addr_nx;

    // Raster step: column fastest, row outer.
    always_comb begin
        w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
        w_col_adv = r_col;
        w_row_adv = r_row;
        if (r_col == COL_LAST) begin
            w_col_adv = '0;
            w_row_adv = r_row + 1'b1;
        end else begin
            w_col_adv = r_col + 1'b1;
            w_row_adv = r_row;
        end
    end

    // Next state and next raster position.
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        case (r_state)
            S_IDLE: begin
                if (bus.startFrame) begin
                    w_row_nx   = '0;
                    w_col_nx   = '0;
                    w_state_nx = r_prev_valid ? S_ERASE : S_FETCH;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ERASE: begin
                if (!r_pixel_write || bus.pixelReady) begin
                    if (w_last) begin
                        w_row_nx   = '0;
                        w_col_nx   = '0;
                        w_state_nx = S_FETCH;
                    end else begin
                        w_row_nx   = w_row_adv;
                        w_col_nx   = w_col_adv;
                    end
                end else begin
                    w_state_nx = S_ERASE;
                end
            end
            S_FETCH: begin
                w_state_nx = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (w_draw_skip) begin
                    if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_row_nx   = w_row_adv;
                        w_col_nx   = w_col_adv;
                        w_state_nx = S_FETCH;
                    end
                end else begin
                    w_state_nx = S_DRAW;
                end
            end
            S_DRAW: begin
                if (bus.pixelReady) begin
                    if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_row_nx   = w_row_adv;
                        w_col_nx   = w_col_adv;
                        w_state_nx = S_FETCH;
                    end
                end else begin
                    w_state_nx = S_DRAW;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Pixel coordinates, clipping and the ROM address for the next texel.
    always_comb begin
        w_erase_x     = {2'b00, r_prev_x} + 10'(w_col_nx);
        w_erase_y     = {1'b0, r_prev_y} + 10'(w_row_nx);
        w_erase_clip  = is_clipped(w_erase_x, w_erase_y);
        w_draw_x      = {2'b00, r_cur_x} + 10'(r_col);
        w_draw_y      = {1'b0, r_cur_y} + 10'(r_row);
        w_draw_skip   = (bus.romData == TRANSPARENT) || is_clipped(w_draw_x, w_draw_y);
        w_id          = (r_state == S_IDLE) ? bus.spriteId : r_cur_id;
        w_rom_addr_nx = 14'(w_id) * ROM_AREA + 14'(w_row_nx) * ROM_STRIDE + 14'(w_col_nx);
    end

    // State, raster position and latched frame geometry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_cur_x      <= 8'd0;
            r_cur_y      <= 9'd0;
            r_cur_id     <= 4'd0;
            r_prev_x     <= 8'd0;
            r_prev_y     <= 9'd0;
            r_prev_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            if (r_state == S_IDLE && bus.startFrame) begin
                r_cur_x  <= bus.xSprite;
                r_cur_y  <= bus.ySprite;
                r_cur_id <= bus.spriteId;
            end
            if (r_state == S_DONE) begin
                r_prev_x     <= r_cur_x;
                r_prev_y     <= r_cur_y;
                r_prev_valid <= 1'b1;
            end
        end
    end

    // Registered outputs, loaded from the state being entered so erase runs at one pixel per cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pixel_write <= 1'b0;
            r_pixel_x     <= 8'd0;
            r_pixel_y     <= 9'd0;
            r_pixel_data  <= 16'd0;
            r_rom_addr    <= 14'd0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_busy       <= (w_state_nx == S_ERASE) || (w_state_nx == S_FETCH) ||
                            (w_state_nx == S_WAIT_ROM) || (w_state_nx == S_DRAW);
            r_frame_done <= (w_state_nx == S_DONE);
            if (w_state_nx == S_FETCH) begin
                r_rom_addr <= w_rom_addr_nx;
            end
            if (w_state_nx == S_ERASE) begin
                r_pixel_write <= !w_erase_clip;
                if (!w_erase_clip) begin
                    r_pixel_x    <= w_erase_x[7:0];
                    r_pixel_y    <= w_erase_y[8:0];
                    r_pixel_data <= BG_COLOUR;
                end
            end else if (r_state == S_WAIT_ROM && w_state_nx == S_DRAW) begin
                r_pixel_write <= 1'b1;
                r_pixel_x     <= w_draw_x[7:0];
                r_pixel_y     <= w_draw_y[8:0];
                r_pixel_data  <= bus.romData;
            end else begin
                r_pixel_write <= (w_state_nx == S_DRAW);
            end
        end
    end

    assign bus.pixelWrite = r_pixel_write;
    assign bus.pixelX     = r_pixel_x;
    assign bus.pixelY     = r_pixel_y;
    assign bus.pixelData  = r_pixel_data;
    assign bus.romAddr    = r_rom_addr;
    assign bus.busy       = r_busy;
    assign bus.frameDone  = r_frame_done;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer with a 4x4 sprite: table of frames,
// randomized frames against a pixel-list reference model, and reset/stall sequences.
module tb_sprite_renderer;

    localparam int          SW = 4;
    localparam int          SH = 4;
    localparam logic [15:0] BG = 16'hFFFF;
    localparam logic [15:0] TR = 16'hF81F;

    typedef struct {
        int x;
        int y;
        int id;
        int mode;
        int ghost;
        int exp_writes;
        int exp_cycles;
    } vec_t;

    logic clock;
    logic resetn;
    sprite_renderer_if bus ();

    sprite_renderer #(.SPRITE_W(SW), .SPRITE_H(SH)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    logic [15:0] rom [0:16383];
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int          fd_cnt;
    int          n_tests;
    int          n_fail;
    bit          m_prev_valid;
    int          m_prev_x;
    int          m_prev_y;
    vec_t        vecs [0:6];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) bus.romData <= rom[bus.romAddr];

    always @(negedge clock) begin
        if (bus.pixelWrite && bus.pixelReady)
            got_q.push_back({bus.pixelX, bus.pixelY, bus.pixelData});
        if (bus.frameDone)
            fd_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: list of expected pixel writes and cycle count for one frame.
    task automatic model_frame(input vec_t v, output int cyc, output int erase_cyc);
        int px;
        int py;
        logic [15:0] t;
        exp_q.delete();
        erase_cyc = 0;
        cyc = 2;
        if (m_prev_valid) begin
            for (int r = 0; r < SH; r++)
                for (int c = 0; c < SW; c++) begin
                    erase_cyc++;
                    px = m_prev_x + c;
                    py = m_prev_y + r;
                    if (px < 240 && py < 320)
                        exp_q.push_back({px[7:0], py[8:0], BG});
                end
        end
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                t  = rom[v.id * SW * SH + r * SW + c];
                px = v.x + c;
                py = v.y + r;
                if (t != TR && px < 240 && py < 320) begin
                    exp_q.push_back({px[7:0], py[8:0], t});
                    cyc += 3;
                end else begin
                    cyc += 2;
                end
            end
        cyc += erase_cyc;
    endtask

    task automatic run_frame(input vec_t v);
        int   exp_cyc;
        int   erase_cyc;
        int   n;
        bit   done;
        int   stall_cnt;
        bit   stall_done;
        logic [32:0] snap;
        int   lim;
        model_frame(v, exp_cyc, erase_cyc);
        if (v.mode == 2) exp_cyc += 7;
        got_q.delete();
        fd_cnt     = 0;
        stall_cnt  = 0;
        stall_done = 1'b0;
        snap       = 33'd0;
        @(posedge clock); #1;
        bus.startFrame = 1'b1;
        bus.xSprite    = 8'(v.x);
        bus.ySprite    = 9'(v.y);
        bus.spriteId   = 4'(v.id);
        bus.pixelReady = (v.mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        n    = 1;
        done = 1'b0;
        @(posedge clock); #1;
        while (!done && n < 3000) begin
            if (v.mode == 2 && !stall_done && (stall_cnt > 0 || (bus.pixelWrite && n >= 1 + erase_cyc))) begin
                if (stall_cnt == 0) begin
                    snap = {bus.pixelX, bus.pixelY, bus.pixelData};
                end else begin
                    chk("stall_hold_pixel", {bus.pixelX, bus.pixelY, bus.pixelData}, snap);
                    chk("stall_hold_write", bus.pixelWrite, 1'b1);
                end
                if (stall_cnt < 7) begin
                    bus.pixelReady = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.pixelReady = 1'b1;
                    stall_done = 1'b1;
                end
            end else if (v.mode == 1) begin
                bus.pixelReady = ($urandom_range(0, 2) != 0);
            end else begin
                bus.pixelReady = 1'b1;
            end
            if (v.ghost != 0 && n + 1 == v.ghost) begin
                bus.startFrame = 1'b1;
                bus.xSprite    = 8'd7;
                bus.ySprite    = 9'd9;
                bus.spriteId   = 4'd1;
            end else begin
                bus.startFrame = 1'b0;
            end
            @(negedge clock);
            n++;
            if (v.mode != 1 && n == 2 + erase_cyc)
                chk("first_rom_addr", bus.romAddr, 64'(v.id * SW * SH));
            if (bus.frameDone) done = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        chk("frame_done_seen", done, 1'b1);
        if (v.mode != 1) chk("frame_cycles", n, exp_cyc);
        if (v.exp_cycles >= 0) chk("frame_cycles_tbl", n, v.exp_cycles);
        bus.startFrame = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("frame_done_once", fd_cnt, 1);
        chk("busy_after_done", bus.busy, 1'b0);
        chk("n_writes", got_q.size(), exp_q.size());
        if (v.exp_writes >= 0) chk("n_writes_tbl", got_q.size(), v.exp_writes);
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++)
            chk($sformatf("pixel_%0d", i), got_q[i], exp_q[i]);
        m_prev_valid = 1'b1;
        m_prev_x     = v.x;
        m_prev_y     = v.y;
    endtask

    initial begin
        vec_t rv;
        int   k;
        n_tests = 0;
        n_fail  = 0;
        fd_cnt  = 0;
        m_prev_valid = 1'b0;
        m_prev_x = 0;
        m_prev_y = 0;
        for (int i = 0; i < 16384; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            rom[0 * 16 + i] = 16'h001F;
            rom[1 * 16 + i] = (i == 5) ? TR : 16'h07E0;
            rom[2 * 16 + i] = 16'h0100 + 16'(i);
            rom[4 * 16 + i] = 16'h1000 + 16'(i);
        end
        for (int s = 5; s < 16; s++)
            for (int i = 0; i < 16; i++)
                rom[s * 16 + i] = ($urandom_range(0, 3) == 0) ? TR : 16'($urandom_range(0, 16'hFFFE));
        for (int i = 0; i < 16; i++)
            rom[3 * 16 + i] = ($urandom_range(0, 3) == 0) ? TR : 16'($urandom_range(0, 16'hFFFE));

        //               x    y    id mode ghost writes cycles
        vecs[0] = '{ 95, 129, 0, 0, 0, 16, 50};
        vecs[1] = '{ 53, 123, 4, 0, 0, 32, 66};
        vecs[2] = '{ 10,  20, 1, 0, 0, 31, 65};
        vecs[3] = '{238, 318, 0, 0, 0, 20, 54};
        vecs[4] = '{100,   5, 2, 0, 0, 20, 66};
        vecs[5] = '{ 60,  60, 0, 2, 0, 32, 73};
        vecs[6] = '{200, 300, 3, 0, 9, -1, -1};

        resetn         = 1'b0;
        bus.startFrame = 1'b0;
        bus.xSprite    = 8'd0;
        bus.ySprite    = 9'd0;
        bus.spriteId   = 4'd0;
        bus.pixelReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pixel_write", bus.pixelWrite, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_frame_done", bus.frameDone, 1'b0);
        chk("rst_outputs", {bus.pixelX, bus.pixelY, bus.pixelData, bus.romAddr}, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        for (int i = 0; i < 10; i++) begin
            rv = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                   int'($urandom_range(0, 15)), 1, 0, -1, -1};
            run_frame(rv);
        end

        // Reset asserted while a sprite pixel is held in DRAW.
        @(posedge clock); #1;
        bus.startFrame = 1'b1;
        bus.xSprite    = 8'd30;
        bus.ySprite    = 9'd40;
        bus.spriteId   = 4'd0;
        bus.pixelReady = 1'b1;
        @(posedge clock); #1;
        bus.startFrame = 1'b0;
        k = 1;
        while (!(bus.pixelWrite && k >= 18) && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        chk("reach_draw", k < 200, 1'b1);
        bus.pixelReady = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        chk("midreset_pixel_write", bus.pixelWrite, 1'b0);
        chk("midreset_busy", bus.busy, 1'b0);
        chk("midreset_outputs", {bus.pixelX, bus.pixelY, bus.pixelData, bus.romAddr}, 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        m_prev_valid = 1'b0;
        rv = '{20, 30, 0, 0, 9, 16, 50};
        run_frame(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
